// File: rtl/bit32_booth_mult.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> signed 2*WIDTH product,
// one add/subtract/no-op step through a ripple adder per clock, WIDTH steps per result.
module bit32_booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             qm1;
  logic [CW-1:0]    count;

  logic             load;
  logic             last_step;
  logic             add_en;
  logic             sub_en;
  logic             cin;
  logic             ovf;
  logic             sign_in;
  logic             c;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] a_new;

  // Booth decode on {Q[0], Qm1}: 01 adds M, 10 subtracts M, 00/11 leave A alone.
  assign add_en = q[0] ^ qm1;
  assign sub_en = q[0] & ~qm1;
  assign in2    = sub_en ? ~m : m;
  assign cin    = sub_en;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ in2[i] ^ c;
      c      = (a[i] & in2[i]) | (c & (a[i] ^ in2[i]));
    end
  end

  // The shifted-in sign must be the sign of the true (WIDTH+1)-bit sum, otherwise
  // M = -2^(WIDTH-1) corrupts A when the adder overflows.
  assign ovf     = add_en & (a[WIDTH-1] == in2[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  assign a_new   = add_en ? sum : a;
  assign sign_in = a_new[WIDTH-1] ^ ovf;

  assign load      = start & ((state == IDLE) | (state == DONE));
  assign last_step = (state == RUN) & (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (count == LAST) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = start ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      m       <= '0;
      count   <= '0;
      product <= '0;
    end else if (load) begin
      m     <= multiplicand;
      a     <= '0;
      q     <= multiplier;
      qm1   <= 1'b0;
      count <= '0;
    end else if (state == RUN) begin
      a     <= {sign_in, a_new[WIDTH-1:1]};
      q     <= {a_new[0], q[WIDTH-1:1]};
      qm1   <= q[0];
      count <= count + 1'b1;
      if (last_step) begin
        product <= {sign_in, a_new[WIDTH-1:1], a_new[0], q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_bit32_booth_mult.sv
// Scoreboard bench for bit32_booth_mult: the driver queues expected products, a
// negedge monitor checks product, latency, busy length and product hold.
module tb_bit32_booth_mult;

  localparam int LAT = 32;

  typedef struct {
    logic [63:0] prod;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  bit32_booth_mult #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    logic [63:0] prev;
    int          busy_cnt;
    exp_t        e;
    prev     = '0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev     = '0;
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 with no pending operation, product %h", product);
          end else begin
            e = exp_q.pop_front();
            check64("product", product, e.prod);
            check64("latency", 64'(cyc - e.acc), 64'(LAT));
            check64("busy_cycles", 64'(busy_cnt), 64'(LAT));
            check64("busy_in_done", {63'b0, busy}, 64'b0);
            $display("op: product=%h expected=%h latency=%0d", product, e.prod, cyc - e.acc);
          end
          busy_cnt = 0;
        end else begin
          check64("product_hold", product, prev);
        end
        prev = product;
      end
    end
  end

  // Called at a negedge; the start edge is the next posedge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [63:0] expv);
    exp_t e;
    start        = 1'b1;
    multiplicand = x;
    multiplier   = y;
    e.prod       = expv;
    e.acc        = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (done) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen within 200 cycles, got done=0 required done=1");
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] expv);
    issue(x, y, expv);
    wait_done();
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'(signed'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    exp_t        e;

    repeat (3) @(negedge clk);
    check64("reset_busy", {63'b0, busy}, 64'b0);
    check64("reset_done", {63'b0, done}, 64'b0);
    check64("reset_product", product, 64'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_op(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op(32'd0, 32'h1234_5678, 64'h0);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

    // start held high with operands toggling during RUN: 11 x -3 only
    start        = 1'b1;
    multiplicand = 32'd11;
    multiplier   = 32'hFFFF_FFFD;
    e.prod       = 64'hFFFF_FFFF_FFFF_FFDF;
    e.acc        = cyc + 1;
    exp_q.push_back(e);
    repeat (20) begin
      @(negedge clk);
      multiplicand = $urandom;
      multiplier   = $urandom;
    end
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // back-to-back: second start in the DONE cycle
    issue(32'd3, 32'd5, 64'hF);
    wait_done();
    issue(32'd2, 32'd9, 64'h12);
    wait_done();
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      x = pick_operand();
      y = pick_operand();
      issue(x, y, ref_mul(x, y));
      wait_done();
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);

    // asynchronous reset in the middle of a run discards it
    issue(32'h0000_1234, 32'h0000_0055, ref_mul(32'h0000_1234, 32'h0000_0055));
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check64("midreset_busy", {63'b0, busy}, 64'b0);
    check64("midreset_done", {63'b0, done}, 64'b0);
    check64("midreset_product", product, 64'b0);
    exp_q.delete(exp_q.size() - 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check64("post_reset_busy", {63'b0, busy}, 64'b0);
    check64("post_reset_done", {63'b0, done}, 64'b0);
    check64("post_reset_product", product, 64'b0);
    run_op(32'd4, 32'd4, 64'h10);

    repeat (5) @(negedge clk);
    check64("pending_empty", 64'(exp_q.size()), 64'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, got running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
